mac_digit_seq: RTL

MAC_DIGIT_SEQ -- requirements
Module: mac_digit_seq

---
 rtl/mac_pkg.sv | 7 +
 rtl/mac_digit_pe.sv | 21 ++
 rtl/mac_digit_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type and digit-counter sizing for the digit-serial MAC.
package mac_pkg;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mac_digit_pe.sv
// mac_digit_pe: combinational carry + a*X for one D-bit digit, signed or unsigned operands.
module mac_digit_pe #(
  parameter int M = 32,
  parameter int D = 1
) (
  input  logic [M+D:0] carry_i,
  input  logic [D-1:0] a_i,
  input  logic [M-1:0] x_i,
  input  logic         a_sgn_i,
  input  logic         x_sgn_i,
  output logic [M+D:0] sum_o
);
  logic signed [D:0]   a_s;
  logic signed [M:0]   x_s;
  logic signed [M+D:0] prod;
  assign a_s   = {a_sgn_i & a_i[D-1], a_i};
  assign x_s   = {x_sgn_i & x_i[M-1], x_i};
  // The true sum always fits M+D+1 signed bits, so modular arithmetic is exact.
  assign prod  = (M+D+1)'(a_s) * (M+D+1)'(x_s);
  assign sum_o = carry_i + prod;
endmodule

// File: rtl/mac_digit_seq.sv
// mac_digit_seq: digit-serial A times parallel X multiplier emitting the N+M-bit product LSB digit first.
module mac_digit_seq
  import mac_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 32,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [M-1:0] X,
  input  logic [D-1:0] a,
  input  logic         a_valid,
  output logic         busy,
  output logic [D-1:0] aX,
  output logic         aX_valid,
  output logic         aX_last
);
  localparam int C  = M + D + 1;
  localparam int CW = cnt_w((N + M) / D);
  localparam logic [CW-1:0] FEED_END = CW'(N / D - 1);
  localparam logic [CW-1:0] LAST     = CW'((N + M) / D - 1);
  if ((N % D) != 0 || (M % D) != 0) begin : g_bad_digit
    $error("mac_digit_seq: D must divide both N and M");
  end
  state_t         state_q, state_d;
  logic [M-1:0]   x_q, x_d;
  logic           sgn_q, sgn_d;
  logic [C-1:0]   carry_q, carry_d, sum;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [D-1:0]   ax_q, ax_d;
  logic           axv_q, axv_d, axl_q, axl_d;
  // Only the most significant A digit carries negative weight in signed mode.
  mac_digit_pe #(.M(M), .D(D)) u_pe (
    .carry_i (carry_q),
    .a_i     (a),
    .x_i     (x_q),
    .a_sgn_i (sgn_q && cnt_q == FEED_END),
    .x_sgn_i (sgn_q),
    .sum_o   (sum)
  );
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    sgn_d   = sgn_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ax_d    = ax_q;
    axv_d   = 1'b0;
    axl_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        x_d     = X;
        sgn_d   = sgn;
        carry_d = '0;
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: if (a_valid) begin
        ax_d    = sum[D-1:0];
        axv_d   = 1'b1;
        carry_d = $signed(sum) >>> D;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == FEED_END) ? FLUSH : FEED;
      end
      FLUSH: begin
        ax_d    = carry_q[D-1:0];
        axv_d   = 1'b1;
        carry_d = $signed(carry_q) >>> D;
        cnt_d   = cnt_q + 1'b1;
        axl_d   = (cnt_q == LAST);
        state_d = (cnt_q == LAST) ? IDLE : FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      sgn_q   <= 1'b0;
      carry_q <= '0;
      cnt_q   <= '0;
      ax_q    <= '0;
      axv_q   <= 1'b0;
      axl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sgn_q   <= sgn_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ax_q    <= ax_d;
      axv_q   <= axv_d;
      axl_q   <= axl_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign aX       = ax_q;
  assign aX_valid = axv_q;
  assign aX_last  = axl_q;
endmodule
